// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: operand/result bundle between the core and the
// iterative multiply/divide unit.
//   start, op, operand_a, operand_b, rd_in, kill : core -> unit request
//   busy, done, result, rd_out                   : unit -> core status/result
// master = core side, slave = mul_div_unit.
interface mul_div_unit_if #(
    parameter int BITS  = 64,
    parameter int DEPTH = 32
);
    localparam int TAGW = $clog2(DEPTH);

    logic            start;
    logic [2:0]      op;
    logic [BITS-1:0] operand_a;
    logic [BITS-1:0] operand_b;
    logic [TAGW-1:0] rd_in;
    logic            kill;
    logic            busy;
    logic            done;
    logic [BITS-1:0] result;
    logic [TAGW-1:0] rd_out;

    modport master (
        output start, op, operand_a, operand_b, rd_in, kill,
        input  busy, done, result, rd_out
    );

    modport slave (
        input  start, op, operand_a, operand_b, rd_in, kill,
        output busy, done, result, rd_out
    );
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV64M multiply/divide unit, fixed BITS+1 cycle
// latency for every op, start/done handshake.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mul_div_unit_if.slave (start/op/operands/rd_in/kill in,
//           busy/done/result/rd_out out)
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | BITS iterations, then one finalize edge (sign fix, result load)
// DONE  | done=1 for one cycle; may accept a new start
module mul_div_unit #(
    parameter int BITS  = 64,
    parameter int DEPTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_div_unit_if.slave bus
);
    localparam int TAGW = $clog2(DEPTH);
    localparam int CW   = $clog2(BITS + 1);
    localparam logic [CW-1:0] LAST = CW'(BITS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state, state_nxt;
    logic              accept, finish, step;
    logic [CW-1:0]     cnt;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [BITS-1:0]   mcand;
    logic [2*BITS-1:0] acc;
    logic [TAGW-1:0]   rd_q;
    logic [BITS-1:0]   result_q;
    logic [TAGW-1:0]   rd_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // kill beats start and also beats the finalize edge
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start && !bus.kill) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (bus.kill) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    finish    = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign step = (state == BUSY) && (cnt != LAST);

    // operand decode at accept: magnitudes plus the sign of the final value
    logic            is_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, neg_in;
    logic [BITS-1:0] a_mag, b_mag;

    always_comb begin
        is_div = bus.op[2];
        a_sgn  = is_div ? ~bus.op[0] : (bus.op[1] ^ bus.op[0]);
        b_sgn  = is_div ? ~bus.op[0] : (bus.op[1:0] == 2'd1);
        a_neg  = a_sgn & bus.operand_a[BITS-1];
        b_neg  = b_sgn & bus.operand_b[BITS-1];
        a_mag  = a_neg ? -bus.operand_a : bus.operand_a;
        b_mag  = b_neg ? -bus.operand_b : bus.operand_b;
        b_zero = (bus.operand_b == '0);
        // divide-by-zero quotient stays all ones, so never negate it;
        // the remainder follows a and naturally comes back as operand_a
        if (is_div) neg_in = bus.op[1] ? a_neg : ((a_neg ^ b_neg) & ~b_zero);
        else        neg_in = a_neg ^ b_neg;
    end

    // one iteration: shift-add multiply or restoring divide step
    logic [BITS:0]     mul_sum, div_trial, div_diff;
    logic [2*BITS-1:0] acc_nxt;

    always_comb begin
        mul_sum   = {1'b0, acc[2*BITS-1:BITS]} + {1'b0, (acc[0] ? mcand : '0)};
        div_trial = acc[2*BITS-1:BITS-1];
        div_diff  = div_trial - {1'b0, mcand};
        if (!op_q[2])        acc_nxt = {mul_sum, acc[BITS-1:1]};
        else if (!div_diff[BITS])
                             acc_nxt = {div_diff[BITS-1:0], acc[BITS-2:0], 1'b1};
        else                 acc_nxt = {div_trial[BITS-1:0], acc[BITS-2:0], 1'b0};
    end

    // finalize: two's-complement fix-up and op-dependent half selection
    logic [2*BITS-1:0] prod;
    logic [BITS-1:0]   div_val, final_res;

    always_comb begin
        prod    = neg_q ? -acc : acc;
        div_val = op_q[1] ? acc[2*BITS-1:BITS] : acc[BITS-1:0];
        if (op_q[2])              final_res = neg_q ? -div_val : div_val;
        else if (op_q[1:0] == '0) final_res = prod[BITS-1:0];
        else                      final_res = prod[2*BITS-1:BITS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            mcand    <= '0;
            acc      <= '0;
            rd_q     <= '0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (accept) begin
            cnt   <= '0;
            op_q  <= bus.op;
            neg_q <= neg_in;
            rd_q  <= bus.rd_in;
            mcand <= is_div ? b_mag : a_mag;
            acc   <= {{BITS{1'b0}}, (is_div ? a_mag : b_mag)};
        end else if (step) begin
            cnt <= cnt + CW'(1);
            acc <= acc_nxt;
        end else if (finish) begin
            result_q <= final_res;
            rd_out_q <= rd_q;
        end
    end

    assign bus.busy   = (state == BUSY);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;
    assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;
    localparam int BITS = 64;
    localparam int DEPTH = 32;
    localparam int LAT = BITS + 1;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;
    int   done_cnt;
    logic [63:0] last_res;
    logic [4:0]  last_rd;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    mul_div_unit_if #(.BITS(BITS), .DEPTH(DEPTH)) bus();

    mul_div_unit #(.BITS(BITS), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // reference: plain 128-bit / signed arithmetic straight from the ISA rules
    function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
        logic [127:0] p;
        longint sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: begin p = {64'b0, a} * {64'b0, b}; return p[63:0]; end
            3'd1: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; return p[127:64]; end
            3'd3: begin p = {64'b0, a} * {64'b0, b}; return p[127:64]; end
            3'd4: begin
                if (b == 0) return ONES;
                if (a == MIN && b == ONES) return MIN;
                return 64'(sa / sb);
            end
            3'd5: return (b == 0) ? ONES : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == ONES) return 64'd0;
                return 64'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // called at a negedge; start is sampled on the following posedge
    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd);
        exp_t e;
        e.res = model(op, a, b);
        e.rd  = rd;
        e.cyc = cyc + 1;
        sb_q.push_back(e);
        last_res = e.res;
        last_rd  = rd;
        bus.start = 1'b1;
        bus.op = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.rd_in = rd;
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 3'($urandom);
        bus.operand_a = {$urandom, $urandom};
        bus.operand_b = {$urandom, $urandom};
        bus.rd_in = 5'($urandom);
    endtask

    task automatic wait_done(string name);
        int n;
        n = 0;
        while (!bus.done && n < 3 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (!bus.done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done within %0d cycles", name, 3 * LAT);
        end
    endtask

    task automatic run(string name, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] rd);
        issue(op, a, b, rd);
        check({name, "_busy"}, 64'(bus.busy), 64'd1);
        wait_done(name);
        @(negedge clk);
    endtask

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 9))
            0: return 64'd0;
            1: return ONES;
            2: return MIN;
            3: return 64'($urandom_range(1, 20));
            4: return -64'($urandom_range(1, 20));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        if (bus.done) begin
            exp_t e;
            done_cnt++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with result %h, expected no done",
                         bus.result);
            end else begin
                e = sb_q.pop_front();
                check("result", bus.result, e.res);
                check("rd_out", 64'(bus.rd_out), 64'(e.rd));
                check("latency", 64'(cyc - e.cyc), 64'(LAT));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        logic [63:0] saved_res;
        logic [4:0]  saved_rd;
        checks = 0;
        errors = 0;
        cyc = 0;
        done_cnt = 0;
        last_res = '0;
        last_rd = '0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.kill = 1'b0;
        bus.op = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.rd_in = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_rd_out", 64'(bus.rd_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("mul_7_m3", 3'd0, 64'd7, -64'd3, 5'd9);
        check("mul_7_m3_value", last_res, 64'hFFFF_FFFF_FFFF_FFEB);
        run("mulhu_ones", 3'd3, ONES, ONES, 5'd1);
        run("mulh_ones", 3'd1, ONES, ONES, 5'd2);
        run("mulhsu_m1_2", 3'd2, ONES, 64'd2, 5'd3);
        run("div_m7_2", 3'd4, -64'd7, 64'd2, 5'd4);
        run("rem_m7_2", 3'd6, -64'd7, 64'd2, 5'd5);
        run("divu_100_7", 3'd5, 64'd100, 64'd7, 5'd6);
        run("remu_100_7", 3'd7, 64'd100, 64'd7, 5'd7);
        run("div_5_0", 3'd4, 64'd5, 64'd0, 5'd8);
        run("div_m5_0", 3'd4, -64'd5, 64'd0, 5'd10);
        run("rem_m5_0", 3'd6, -64'd5, 64'd0, 5'd11);
        run("remu_5_0", 3'd7, 64'd5, 64'd0, 5'd12);
        run("div_ovf", 3'd4, MIN, ONES, 5'd13);
        run("rem_ovf", 3'd6, MIN, ONES, 5'd14);

        // start while busy is ignored
        issue(3'd0, 64'd12345, 64'd678, 5'd15);
        repeat (9) @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'd5;
        bus.operand_a = 64'd99;
        bus.operand_b = 64'd3;
        bus.rd_in = 5'd30;
        @(negedge clk);
        bus.start = 1'b0;
        check("ignored_start_busy", 64'(bus.busy), 64'd1);
        wait_done("ignored_start");

        // back-to-back: new start in the done cycle
        issue(3'd1, MIN, 64'd3, 5'd16);
        check("b2b_busy", 64'(bus.busy), 64'd1);
        wait_done("b2b");
        @(negedge clk);

        // async reset mid-operation
        issue(3'd4, 64'd1000, 64'd7, 5'd17);
        repeat (29) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.busy), 64'd0);
        check("midrst_done", 64'(bus.done), 64'd0);
        check("midrst_result", bus.result, 64'd0);
        check("midrst_rd_out", 64'(bus.rd_out), 64'd0);
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        d0 = done_cnt;
        repeat (2 * LAT) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt), 64'(d0));

        // kill mid-operation with a simultaneous start
        run("pre_kill", 3'd7, 64'd77, 64'd10, 5'd18);
        saved_res = last_res;
        saved_rd = last_rd;
        issue(3'd0, 64'd5, 64'd6, 5'd19);
        repeat (29) @(negedge clk);
        bus.kill = 1'b1;
        bus.start = 1'b1;
        bus.op = 3'd3;
        bus.rd_in = 5'd20;
        @(negedge clk);
        bus.kill = 1'b0;
        bus.start = 1'b0;
        void'(sb_q.pop_back());
        check("kill_busy", 64'(bus.busy), 64'd0);
        check("kill_result", bus.result, saved_res);
        check("kill_rd_out", 64'(bus.rd_out), 64'(saved_rd));
        d0 = done_cnt;
        repeat (2 * LAT) @(negedge clk);
        check("kill_no_done", 64'(done_cnt), 64'(d0));

        // random ops, some issued back-to-back in the done cycle
        for (int i = 0; i < 40; i++) begin
            issue(3'($urandom), pick(), pick(), 5'($urandom));
            wait_done("rand");
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
        repeat (3) @(negedge clk);
        check("final_queue_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative RV64M multiply/divide execution unit sitting directly downstream of the register file.
- Consumes the two register-file read ports as operands; produces a result plus destination address for the register-file write port.
- Fixed-latency, start/done handshake so the core's stall logic can freeze the PC while busy.

Parameters:
- BITS, 64, operand/result width; must equal the register-file data width.
- DEPTH, 32, register count; destination tag width is $clog2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- op  input  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- operand_a  input  BITS  rs1 value, from register-file read1.
- operand_b  input  BITS  rs2 value, from register-file read2.
- rd_in  input  $clog2(DEPTH)  destination register tag.
- kill  input  1  synchronous abort of any in-flight operation.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: result/rd_out valid.
- result  output  BITS  computed value, held until the next accepted start.
- rd_out  output  $clog2(DEPTH)  tag captured with the operation.

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, result=0, rd_out=0; any in-flight work discarded; takes effect immediately, including mid-operation.
- States: IDLE, BUSY, DONE.
  - IDLE/DONE + start=1 + kill=0 -> BUSY; op, operands and rd_in latched; iteration counter=0.
  - BUSY: one iteration per clock; after BITS iterations -> DONE.
  - DONE: done=1 for exactly one cycle, then IDLE unless a new start is accepted that same cycle (back-to-back allowed).
- Latency: start sampled at edge E0 -> busy=1 after E0; iterations on edges E1..E_BITS; at edge E_(BITS+1) busy=0, done=1, result valid. Fixed BITS+1 cycles for every op, including special cases.
- start while busy=1: ignored, no effect on latched state.
- Inputs may change freely after the accepting edge.
- kill=1: at the next edge -> IDLE, busy=0, no done pulse, result/rd_out unchanged.
  - kill has priority over a simultaneous start; that start is dropped.
- Multiply:
  - Shift-add over 2*BITS-bit product.
  - MUL returns the low BITS of the product.
  - MULH/MULHSU/MULHU return the high BITS.
  - Signedness: MULH signed x signed; MULHSU rs1 signed x rs2 unsigned; MULHU unsigned x unsigned.
  - Signed ops use magnitude multiply then two's-complement negation of the 2*BITS product when signs differ.
- Divide:
  - Restoring, one quotient bit per cycle on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a).
  - Truncation toward zero.
- Divide by zero (b=0):
  - DIV/DIVU result = all ones.
  - REM/REMU result = operand_a.
- Signed overflow (DIV/REM, a = -2^(BITS-1), b = -1):
  - DIV result = -2^(BITS-1).
  - REM result = 0.
- Special-case results are still delivered at the fixed latency.
- result and rd_out update only on the done edge.

Test Plan:
- MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> result 0xFFFF_FFFF_FFFF_FFEB (-21), done exactly 65 cycles after start, rd_out = rd_in.
- MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE; MULH same operands -> 0; MULHSU a=-1, b=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- DIV -7/2 -> 0xFFFF_FFFF_FFFF_FFFD (-3); REM -7,2 -> 0xFFFF_FFFF_FFFF_FFFF (-1); DIVU 100/7 -> 14; REMU 100,7 -> 2.
- Divide by zero: DIV 5/0 -> all ones; REMU 5,0 -> 5. Overflow: DIV 0x8000_0000_0000_0000 / -1 -> 0x8000_0000_0000_0000; REM same -> 0. All at 65-cycle latency.
- Handshake: start pulsed at cycle 10 while busy -> ignored, original result delivered. New start in the done cycle -> busy=1 next cycle, second done 65 cycles later.
- rst_n low at iteration 30 -> busy/done/result/rd_out = 0 immediately, no done pulse. kill at iteration 30 with simultaneous start -> IDLE, no done, previous result retained.
